// File: rtl/gj_axis_uart_pkg.sv
// Shared definitions for the UART AXIS Rx packetizer and its Tx framer counterpart.
package gj_axis_uart_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL1  = 2'd1,
    STREAM = 2'd2,
    FLUSH  = 2'd3
  } rx_state_e;

  localparam logic [7:0] CRC8_POLY = 8'h07;
  localparam logic [7:0] CRC8_INIT = 8'h00;

  // One byte of MSB-first CRC-8 with an arbitrary polynomial (no reflect, no xorout)
  function automatic logic [7:0] crc8_step_poly(input logic [7:0] crc,
                                                 input logic [7:0] d,
                                                 input logic [7:0] poly);
    logic [7:0] c;
    c = crc ^ d;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ poly) : (c << 1);
    end
    return c;
  endfunction

  // One byte of CRC-8 with the standard polynomial
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] d);
    return crc8_step_poly(crc, d, CRC8_POLY);
  endfunction

endpackage

// File: rtl/gj_axis_uart_rx_pkt.sv
// Rx packetizer: frames the raw UART byte stream by line-idle timeout and strips/checks a trailing CRC-8.
module gj_axis_uart_rx_pkt
  import gj_axis_uart_pkg::*;
#(
  parameter int unsigned GAP_W    = 16,
  parameter logic [7:0]  CRC_POLY = CRC8_POLY
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_en,
  input  logic [GAP_W-1:0] gapBits,
  input  logic             crcEn,
  input  logic             in_tvalid,
  input  logic [7:0]       in_tdata,
  input  logic             in_tuser,
  output logic             rx_tvalid,
  output logic [7:0]       rx_tdata,
  output logic             rx_tlast,
  output logic             rx_tuser,
  output logic             runtPkt,
  output logic             busy
);

  rx_state_e        state_q, state_d;
  logic [7:0]       h0_q, h0_d;
  logic [7:0]       h1_q, h1_d;
  logic [7:0]       crc_q, crc_d;
  logic             perr_q, perr_d;
  logic [GAP_W-1:0] cnt_q, cnt_d;
  logic             tvalid_q, tvalid_d;
  logic [7:0]       tdata_q, tdata_d;
  logic             tlast_q, tlast_d;
  logic             tuser_q, tuser_d;
  logic             runt_q, runt_d;
  logic             busy_q, busy_d;

  logic             bypass;
  logic             timeout;
  logic             close;
  logic [7:0]       crc_base;
  logic             perr_base;
  logic [GAP_W:0]   cnt_inc;

  assign bypass  = (gapBits == '0);
  assign cnt_inc = {1'b0, cnt_q} + (GAP_W+1)'(1);
  // ">=" rather than "==" so a gapBits reduced mid-packet still times out instead of hanging
  assign timeout = clk_en && !in_tvalid && (state_q != IDLE) && (cnt_inc >= {1'b0, gapBits});

  // Next-state, hold registers, idle counter, CRC/error accumulation and output beat
  always_comb begin
    state_d   = state_q;
    h0_d      = h0_q;
    h1_d      = h1_q;
    cnt_d     = cnt_q;
    tvalid_d  = 1'b0;
    tdata_d   = 8'h00;
    tlast_d   = 1'b0;
    tuser_d   = 1'b0;
    runt_d    = 1'b0;
    close     = 1'b0;
    crc_base  = crc_q;
    perr_base = perr_q;
    crc_d     = crc_q;
    perr_d    = perr_q;

    if (in_tvalid) begin
      cnt_d = '0;
    end else if (clk_en && (state_q != IDLE) && (cnt_q < gapBits)) begin
      cnt_d = cnt_q + GAP_W'(1);
    end

    if (bypass) begin
      state_d = IDLE;
      crc_d   = CRC8_INIT;
      perr_d  = 1'b0;
      if (in_tvalid) begin
        tvalid_d = 1'b1;
        tdata_d  = in_tdata;
        tlast_d  = 1'b1;
        tuser_d  = in_tuser;
      end
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_tvalid) begin
            h1_d    = in_tdata;
            state_d = FILL1;
          end
        end
        FILL1: begin
          if (in_tvalid) begin
            h0_d    = h1_q;
            h1_d    = in_tdata;
            state_d = STREAM;
          end else if (timeout) begin
            close   = 1'b1;
            state_d = IDLE;
            if (crcEn) begin
              runt_d = 1'b1;
            end else begin
              tvalid_d = 1'b1;
              tdata_d  = h1_q;
              tlast_d  = 1'b1;
              tuser_d  = perr_q;
            end
          end
        end
        STREAM: begin
          if (in_tvalid) begin
            tvalid_d = 1'b1;
            tdata_d  = h0_q;
            h0_d     = h1_q;
            h1_d     = in_tdata;
          end else if (timeout) begin
            tvalid_d = 1'b1;
            tdata_d  = h0_q;
            if (crcEn) begin
              // h1 holds the CRC byte and is dropped
              tlast_d = 1'b1;
              tuser_d = (crc_q != CRC8_INIT) | perr_q;
              close   = 1'b1;
              state_d = IDLE;
            end else begin
              state_d = FLUSH;
            end
          end
        end
        FLUSH: begin
          tvalid_d = 1'b1;
          tdata_d  = h1_q;
          tlast_d  = 1'b1;
          tuser_d  = perr_q;
          close    = 1'b1;
          if (in_tvalid) begin
            h1_d    = in_tdata;
            state_d = FILL1;
          end else begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase

      // A closing packet restarts accumulation; a byte arriving that cycle belongs to the next one
      crc_base  = close ? CRC8_INIT : crc_q;
      perr_base = close ? 1'b0 : perr_q;
      crc_d     = crc_base;
      perr_d    = perr_base;
      if (in_tvalid) begin
        crc_d  = crc8_step_poly(crc_base, in_tdata, CRC_POLY);
        perr_d = perr_base | in_tuser;
      end
    end

    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset discards any held bytes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      h0_q     <= 8'h00;
      h1_q     <= 8'h00;
      crc_q    <= CRC8_INIT;
      perr_q   <= 1'b0;
      cnt_q    <= '0;
      tvalid_q <= 1'b0;
      tdata_q  <= 8'h00;
      tlast_q  <= 1'b0;
      tuser_q  <= 1'b0;
      runt_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      h0_q     <= h0_d;
      h1_q     <= h1_d;
      crc_q    <= crc_d;
      perr_q   <= perr_d;
      cnt_q    <= cnt_d;
      tvalid_q <= tvalid_d;
      tdata_q  <= tdata_d;
      tlast_q  <= tlast_d;
      tuser_q  <= tuser_d;
      runt_q   <= runt_d;
      busy_q   <= busy_d;
    end
  end

  assign rx_tvalid = tvalid_q;
  assign rx_tdata  = tdata_q;
  assign rx_tlast  = tlast_q;
  assign rx_tuser  = tuser_q;
  assign runtPkt   = runt_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_gj_axis_uart_rx_pkt.sv
// Bench for the Rx packetizer: packet-level reference model feeding a scoreboard checked by a monitor.
module tb_gj_axis_uart_rx_pkt;

  logic        clk;
  logic        rst;
  logic        clk_en;
  logic [15:0] gapBits;
  logic        crcEn;
  logic        in_tvalid;
  logic [7:0]  in_tdata;
  logic        in_tuser;
  logic        rx_tvalid;
  logic [7:0]  rx_tdata;
  logic        rx_tlast;
  logic        rx_tuser;
  logic        runtPkt;
  logic        busy;

  gj_axis_uart_rx_pkt dut (
    .clk       (clk),
    .rst       (rst),
    .clk_en    (clk_en),
    .gapBits   (gapBits),
    .crcEn     (crcEn),
    .in_tvalid (in_tvalid),
    .in_tdata  (in_tdata),
    .in_tuser  (in_tuser),
    .rx_tvalid (rx_tvalid),
    .rx_tdata  (rx_tdata),
    .rx_tlast  (rx_tlast),
    .rx_tuser  (rx_tuser),
    .runtPkt   (runtPkt),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
    logic       u;
  } beat_t;

  beat_t      exp_q[$];
  beat_t      act_q[$];
  logic [7:0] pkt_b[$];
  bit         pkt_e[$];
  int         exp_runt = 0;
  int         act_runt = 0;
  int         checks   = 0;
  int         passes   = 0;
  int         g_cfg    = 4;
  bit         crc_cfg  = 1'b1;
  int         p_cfg    = 1;
  int         phase    = 0;
  int         ce_since = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // CRC-8/0x07 as polynomial division of the bit stream, MSB first
  function automatic logic [7:0] ref_crc(input int n);
    logic [7:0] c;
    logic [7:0] b;
    logic       fb;
    c = 8'h00;
    for (int i = 0; i < n; i++) begin
      b = pkt_b[i];
      for (int k = 7; k >= 0; k--) begin
        fb = c[7] ^ b[k];
        c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
      end
    end
    return c;
  endfunction

  // Turn a completed packet into the beats (or runt) the receiver must produce
  task automatic close_pkt();
    int    n;
    bit    anyerr;
    beat_t bt;
    n      = pkt_b.size();
    anyerr = 1'b0;
    for (int i = 0; i < n; i++) anyerr |= pkt_e[i];
    if (n > 0) begin
      if (crc_cfg) begin
        if (n == 1) exp_runt++;
        for (int i = 0; i < n - 1; i++) begin
          bt.d = pkt_b[i];
          bt.l = (i == n - 2);
          bt.u = (i == n - 2) ? ((ref_crc(n) != 8'h00) || anyerr) : 1'b0;
          exp_q.push_back(bt);
        end
      end else begin
        for (int i = 0; i < n; i++) begin
          bt.d = pkt_b[i];
          bt.l = (i == n - 1);
          bt.u = (i == n - 1) ? anyerr : 1'b0;
          exp_q.push_back(bt);
        end
      end
    end
    pkt_b.delete();
    pkt_e.delete();
  endtask

  // Drive one clock cycle; a packet ends once gapBits bit-times pass with no byte between two bytes
  task automatic step(input bit v, input logic [7:0] d, input bit u);
    bit    ce;
    beat_t bt;
    ce        = (phase == 0);
    phase     = (phase + 1) % p_cfg;
    clk_en    = ce;
    in_tvalid = v;
    in_tdata  = d;
    in_tuser  = u;
    if (v) begin
      if (g_cfg == 0) begin
        bt.d = d; bt.l = 1'b1; bt.u = u;
        exp_q.push_back(bt);
      end else begin
        if (pkt_b.size() > 0 && ce_since >= g_cfg) close_pkt();
        pkt_b.push_back(d);
        pkt_e.push_back(u);
      end
      ce_since = 0;
    end else if (ce) begin
      ce_since++;
    end
    @(posedge clk);
    #1;
    in_tvalid = 1'b0;
  endtask

  task automatic idle_long();
    repeat ((g_cfg + 2) * p_cfg + 4) step(1'b0, 8'h00, 1'b0);
    if (pkt_b.size() > 0 && ce_since >= g_cfg) close_pkt();
    chk("busy_after_idle", int'(busy), 0);
  endtask

  task automatic set_cfg(input int g, input bit c, input int p);
    g_cfg   = g;
    crc_cfg = c;
    p_cfg   = p;
    phase   = 0;
    gapBits = 16'(g);
    crcEn   = c;
  endtask

  task automatic send_burst(input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] b3,
                            input int n, input int err_idx);
    logic [7:0] bs[4];
    bs[0] = b0; bs[1] = b1; bs[2] = b2; bs[3] = b3;
    for (int i = 0; i < n; i++) step(1'b1, bs[i], (i == err_idx));
  endtask

  // Monitor: capture every output beat and retire it against the scoreboard
  always @(negedge clk) begin
    beat_t a;
    beat_t e;
    if (!rst) begin
      if (rx_tvalid) begin
        a.d = rx_tdata; a.l = rx_tlast; a.u = rx_tuser;
        act_q.push_back(a);
      end
      if (runtPkt) act_runt++;
      while (exp_q.size() > 0 && act_q.size() > 0) begin
        a = act_q.pop_front();
        e = exp_q.pop_front();
        checks++;
        if (a == e) passes++;
        else $display("FAIL beat: got d=%h last=%b user=%b, expected d=%h last=%b user=%b",
                      a.d, a.l, a.u, e.d, e.l, e.u);
      end
    end
  end

  initial begin
    int         r0;
    int         n;
    int         gap;
    logic [7:0] d;
    bit         u;

    rst = 1'b1; clk_en = 1'b0; in_tvalid = 1'b0; in_tdata = 8'h00; in_tuser = 1'b0;
    set_cfg(4, 1'b1, 2);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", int'({rx_tvalid, rx_tdata, rx_tlast, rx_tuser, runtPkt, busy}), 0);
    rst = 1'b0;

    // Good CRC packet, then the same with a corrupted CRC byte
    step(1'b1, 8'h01, 1'b0);
    chk("busy_mid_pkt", int'(busy), 1);
    send_burst(8'h02, 8'h03, 8'h48, 8'h00, 3, -1);
    idle_long();
    send_burst(8'h01, 8'h02, 8'h03, 8'h49, 4, -1);
    idle_long();

    // Single byte with CRC enabled is a runt
    r0 = act_runt;
    step(1'b1, 8'hAA, 1'b0);
    idle_long();
    chk("runt_pulses", act_runt - r0, 1);

    // No CRC: two bytes, second flagged, closed through FLUSH
    set_cfg(4, 1'b0, 2);
    send_burst(8'h11, 8'h22, 8'h00, 8'h00, 2, 1);
    idle_long();

    // Byte in the exact timeout cycle continues the packet; byte in the FLUSH cycle opens a new one
    set_cfg(4, 1'b0, 1);
    step(1'b1, 8'h33, 1'b0);
    repeat (3) step(1'b0, 8'h00, 1'b0);
    step(1'b1, 8'h44, 1'b0);
    repeat (4) step(1'b0, 8'h00, 1'b0);
    step(1'b1, 8'h55, 1'b0);
    idle_long();
    set_cfg(4, 1'b1, 1);
    step(1'b1, 8'h5A, 1'b0);
    repeat (3) step(1'b0, 8'h00, 1'b0);
    step(1'b1, ref_crc(1), 1'b0);
    idle_long();

    // Bypass mode
    set_cfg(0, 1'b1, 1);
    send_burst(8'h5A, 8'hA5, 8'h00, 8'h00, 2, -1);
    idle_long();

    // Randomized packets with random configuration and spacing
    for (int it = 0; it < 40; it++) begin
      set_cfg($urandom_range(0, 5), 1'($urandom_range(0, 1)), $urandom_range(1, 3));
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) begin
        if (i > 0) begin
          gap = $urandom_range(0, (g_cfg + 1) * p_cfg);
          repeat (gap) step(1'b0, 8'h00, 1'b0);
        end
        d = 8'($urandom_range(0, 255));
        if (crc_cfg && i == n - 1 && $urandom_range(0, 1) == 1) d = ref_crc(pkt_b.size());
        u = ($urandom_range(0, 9) == 0);
        step(1'b1, d, u);
      end
      idle_long();
    end

    // Reset with two bytes held: nothing may come out
    set_cfg(4, 1'b1, 1);
    send_burst(8'h01, 8'h02, 8'h00, 8'h00, 2, -1);
    rst = 1'b1;
    #1;
    chk("reset_mid_pkt_outputs", int'({rx_tvalid, rx_tdata, rx_tlast, rx_tuser, runtPkt, busy}), 0);
    pkt_b.delete();
    pkt_e.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    ce_since = 0;
    idle_long();

    repeat (4) @(posedge clk);
    #1;
    chk("unexpected_beats", act_q.size(), 0);
    chk("missing_beats", exp_q.size(), 0);
    chk("runt_total", act_runt, exp_runt);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
